// File: rtl/cache_victim_fill_ctrl_pkg.sv
// Shared types and widths for the miss-side victim writeback / line fill controller.
package cache_victim_fill_ctrl_pkg;

    localparam int unsigned ADDR_BITS = 16;
    localparam int unsigned OFF_BITS  = 4;
    localparam int unsigned SET_BITS  = 3;
    localparam int unsigned LINE_BITS = 128;
    localparam int unsigned WAY_BITS  = 4;
    localparam int unsigned TAG_BITS  = ADDR_BITS - SET_BITS - OFF_BITS;
    localparam int unsigned CNT_BITS  = 16;

    localparam logic [ADDR_BITS-1:0] OFF_MASK = ADDR_BITS'((1 << OFF_BITS) - 1);

    typedef logic [WAY_BITS-1:0]  lc3b_way;
    typedef logic [SET_BITS-1:0]  lc3b_set_idx;
    typedef logic [TAG_BITS-1:0]  lc3b_cache_tag;
    typedef logic [LINE_BITS-1:0] lc3b_cache_line;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        WB,
        FETCH,
        INSTALL
    } vfc_state_t;

    // Clears the line offset so memory only ever sees line-aligned addresses.
    function automatic logic [ADDR_BITS-1:0] line_align(input logic [ADDR_BITS-1:0] a);
        return a & ~OFF_MASK;
    endfunction

endpackage

// File: rtl/cache_victim_fill_ctrl_sat_counter16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter16 (
    input  logic        inc,
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] count
);

    logic [15:0] count_q;
    logic [15:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 16'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cache_victim_fill_ctrl.sv
// Miss handler: latches the PLRU victim, writes it back if dirty, fetches and installs the
// missing line, then marks the filled way most-recently-used.
module cache_victim_fill_ctrl
    import cache_victim_fill_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    input  logic [ADDR_BITS-1:0] req_addr,
    output logic                 req_ready,
    output logic [SET_BITS-1:0]  arr_index,
    input  logic [WAY_BITS-1:0]  victim_way,
    input  logic                 victim_valid,
    input  logic                 victim_dirty,
    input  logic [TAG_BITS-1:0]  victim_tag,
    input  logic [LINE_BITS-1:0] victim_data,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [LINE_BITS-1:0] mem_wdata,
    input  logic [LINE_BITS-1:0] mem_rdata,
    input  logic                 mem_resp,
    output logic                 fill_we,
    output logic [WAY_BITS-1:0]  fill_way,
    output logic [TAG_BITS-1:0]  fill_tag,
    output logic [LINE_BITS-1:0] fill_data,
    output logic                 lru_load,
    output logic [WAY_BITS-1:0]  lru_hit,
    output logic                 done,
    output logic [CNT_BITS-1:0]  wb_count,
    output logic [CNT_BITS-1:0]  fill_count
);

    vfc_state_t           state_q, state_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    lc3b_way              way_q, way_d;
    logic                 req_ready_q, req_ready_d;
    logic                 mem_read_q, mem_read_d;
    logic                 mem_write_q, mem_write_d;
    logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
    lc3b_cache_line       mem_wdata_q, mem_wdata_d;
    logic                 install_q, install_d;
    lc3b_way              fill_way_q, fill_way_d;
    lc3b_cache_tag        fill_tag_q, fill_tag_d;
    lc3b_cache_line       fill_data_q, fill_data_d;
    logic                 wb_inc;
    logic                 fill_inc;

    // Next state; every output flop is decoded from the next state so strobes never glitch.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        way_d       = way_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        fill_way_d  = fill_way_q;
        fill_tag_d  = fill_tag_q;
        fill_data_d = fill_data_q;
        wb_inc      = 1'b0;
        fill_inc    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    state_d = SELECT;
                end
            end
            SELECT: begin
                way_d = victim_way;
                if (victim_valid && victim_dirty) begin
                    mem_addr_d  = line_align({victim_tag, addr_q[OFF_BITS+SET_BITS-1:0]});
                    mem_wdata_d = victim_data;
                    state_d     = WB;
                end else begin
                    mem_addr_d = line_align(addr_q);
                    state_d    = FETCH;
                end
            end
            WB: begin
                if (mem_resp) begin
                    wb_inc     = 1'b1;
                    mem_addr_d = line_align(addr_q);
                    state_d    = FETCH;
                end
            end
            FETCH: begin
                if (mem_resp) begin
                    fill_inc    = 1'b1;
                    fill_data_d = mem_rdata;
                    fill_way_d  = way_q;
                    fill_tag_d  = addr_q[ADDR_BITS-1 -: TAG_BITS];
                    state_d     = INSTALL;
                end
            end
            INSTALL: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
        mem_write_d = (state_d == WB);
        mem_read_d  = (state_d == FETCH);
        install_d   = (state_d == INSTALL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            way_q       <= '0;
            req_ready_q <= 1'b1;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            install_q   <= 1'b0;
            fill_way_q  <= '0;
            fill_tag_q  <= '0;
            fill_data_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            way_q       <= way_d;
            req_ready_q <= req_ready_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            install_q   <= install_d;
            fill_way_q  <= fill_way_d;
            fill_tag_q  <= fill_tag_d;
            fill_data_q <= fill_data_d;
        end
    end

    sat_counter16 u_wb_cnt (
        .inc   (wb_inc),
        .clk   (clk),
        .rst_n (rst_n),
        .count (wb_count)
    );

    sat_counter16 u_fill_cnt (
        .inc   (fill_inc),
        .clk   (clk),
        .rst_n (rst_n),
        .count (fill_count)
    );

    assign req_ready = req_ready_q;
    assign arr_index = addr_q[OFF_BITS +: SET_BITS];
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign fill_we   = install_q;
    assign fill_way  = fill_way_q;
    assign fill_tag  = fill_tag_q;
    assign fill_data = fill_data_q;
    assign lru_load  = install_q;
    assign lru_hit   = fill_way_q;
    assign done      = install_q;

endmodule

// File: tb/tb_cache_victim_fill_ctrl.sv
// Scoreboard bench: each miss pushes its expected WB/FETCH/INSTALL events, a negedge monitor pops them.
module tb_cache_victim_fill_ctrl;

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic [15:0]  req_addr;
    logic         req_ready;
    logic [2:0]   arr_index;
    logic [3:0]   victim_way;
    logic         victim_valid;
    logic         victim_dirty;
    logic [8:0]   victim_tag;
    logic [127:0] victim_data;
    logic         mem_read;
    logic         mem_write;
    logic [15:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_resp;
    logic         fill_we;
    logic [3:0]   fill_way;
    logic [8:0]   fill_tag;
    logic [127:0] fill_data;
    logic         lru_load;
    logic [3:0]   lru_hit;
    logic         done;
    logic [15:0]  wb_count;
    logic [15:0]  fill_count;

    cache_victim_fill_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_ready    (req_ready),
        .arr_index    (arr_index),
        .victim_way   (victim_way),
        .victim_valid (victim_valid),
        .victim_dirty (victim_dirty),
        .victim_tag   (victim_tag),
        .victim_data  (victim_data),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_resp     (mem_resp),
        .fill_we      (fill_we),
        .fill_way     (fill_way),
        .fill_tag     (fill_tag),
        .fill_data    (fill_data),
        .lru_load     (lru_load),
        .lru_hit      (lru_hit),
        .done         (done),
        .wb_count     (wb_count),
        .fill_count   (fill_count)
    );

    localparam int K_WB    = 0;
    localparam int K_FETCH = 1;
    localparam int K_INST  = 2;

    typedef struct {
        int           kind;
        logic [15:0]  addr;
        logic [127:0] data;
        logic [3:0]   way;
        logic [8:0]   tag;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_wb   = 0;
    int   exp_fill = 0;
    logic prev_w   = 1'b0;
    logic prev_r   = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_event(input int kind);
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_underrun", 128'(kind + 1), 128'(0));
            return;
        end
        e = sb.pop_front();
        check("ev_kind", 128'(kind), 128'(e.kind));
        if (kind == K_WB) begin
            check("wb_addr", 128'(mem_addr), 128'(e.addr));
            check("wb_wdata", mem_wdata, e.data);
        end else if (kind == K_FETCH) begin
            check("fetch_addr", 128'(mem_addr), 128'(e.addr));
        end else begin
            check("fill_way", 128'(fill_way), 128'(e.way));
            check("lru_hit", 128'(lru_hit), 128'(e.way));
            check("fill_tag", 128'(fill_tag), 128'(e.tag));
            check("fill_data", fill_data, e.data);
            check("lru_load", 128'(lru_load), 128'(1));
            check("done", 128'(done), 128'(1));
        end
    endtask

    // Monitor: rising strobes and install pulses consume scoreboard entries.
    always @(negedge clk) begin
        check("rw_excl", 128'(mem_read & mem_write), 128'(0));
        if (mem_write && !prev_w) expect_event(K_WB);
        if (mem_read && !prev_r) expect_event(K_FETCH);
        if (fill_we) expect_event(K_INST);
        prev_w <= mem_write;
        prev_r <= mem_read;
    end

    // Runs one miss starting at a negedge; j = WB cycles, k = FETCH cycles (each incl. mem_resp).
    task automatic run_miss(input logic [15:0] addr, input logic [3:0] way, input logic vv,
                            input logic vd, input logic [8:0] vt, input logic [127:0] vdat,
                            input int j, input int k, input logic [127:0] rdat,
                            input logic hold, input logic stray, output int n_wait);
        exp_t        e;
        int          lat;
        logic [15:0] addr_before;
        logic        dirty_wb;
        dirty_wb = vv && vd;
        if (dirty_wb) begin
            e = '{K_WB, {vt, addr[6:4], 4'h0}, vdat, 4'h0, 9'h0};
            sb.push_back(e);
        end
        e = '{K_FETCH, {addr[15:4], 4'h0}, 128'h0, 4'h0, 9'h0};
        sb.push_back(e);
        e = '{K_INST, 16'h0, rdat, way, addr[15:7]};
        sb.push_back(e);

        req_addr     = addr;
        victim_way   = way;
        victim_valid = vv;
        victim_dirty = vd;
        victim_tag   = vt;
        victim_data  = vdat;
        req_valid    = 1'b1;
        n_wait = 0;
        while (!req_ready && n_wait < 40) begin
            @(negedge clk);
            n_wait++;
        end
        if (n_wait >= 40) begin
            check("accept_timeout", 128'(req_ready), 128'(1));
            req_valid = 1'b0;
            sb.delete();
            return;
        end
        addr_before = mem_addr;
        @(posedge clk);
        @(negedge clk);
        lat = 1;
        if (!hold) req_valid = 1'b0;
        check("sel_index", 128'(arr_index), 128'(addr[6:4]));
        check("sel_ready", 128'(req_ready), 128'(0));
        check("sel_addr_hold", 128'(mem_addr), 128'(addr_before));
        if (stray) mem_resp = 1'b1;

        if (dirty_wb) begin
            @(negedge clk);
            lat++;
            mem_resp = 1'b0;
            for (int c = 1; c < j; c++) begin
                check("wb_strobe", 128'(mem_write), 128'(1));
                @(negedge clk);
                lat++;
            end
            mem_resp = 1'b1;
        end
        @(negedge clk);
        lat++;
        mem_resp = 1'b0;
        check("fetch_ready", 128'(req_ready), 128'(0));
        check("wb_cnt_mid", 128'(wb_count), 128'(exp_wb + (dirty_wb ? 1 : 0)));
        check("fill_cnt_mid", 128'(fill_count), 128'(exp_fill));
        for (int c = 1; c < k; c++) begin
            @(negedge clk);
            lat++;
            check("fetch_strobe", 128'(mem_read), 128'(1));
        end
        mem_rdata = rdat;
        mem_resp  = 1'b1;
        @(negedge clk);
        lat++;
        mem_resp = 1'b0;
        check("inst_ready", 128'(req_ready), 128'(0));
        check("inst_we", 128'(fill_we), 128'(1));
        @(negedge clk);
        lat++;
        check("idle_ready", 128'(req_ready), 128'(1));
        check("idle_done", 128'(done), 128'(0));
        check("idle_cycle", 128'(lat + 1), 128'(4 + (dirty_wb ? j : 0) + k));
        if (dirty_wb) exp_wb++;
        exp_fill++;
        check("wb_count", 128'(wb_count), 128'(exp_wb));
        check("fill_count", 128'(fill_count), 128'(exp_fill));
    endtask

    initial begin
        int          nw;
        exp_t        e;
        logic [15:0] addr_save;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_addr     = 16'h0;
        victim_way   = 4'h0;
        victim_valid = 1'b0;
        victim_dirty = 1'b0;
        victim_tag   = 9'h0;
        victim_data  = 128'h0;
        mem_rdata    = 128'h0;
        mem_resp     = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", 128'(req_ready), 128'(1));
        check("rst_read", 128'(mem_read), 128'(0));
        check("rst_write", 128'(mem_write), 128'(0));
        check("rst_fill_we", 128'(fill_we), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_addr", 128'(mem_addr), 128'(0));
        check("rst_counts", 128'({wb_count, fill_count}), 128'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Clean miss, then dirty victim, then invalid-but-dirty victim with an unaligned address.
        run_miss(16'h1230, 4'd5, 1'b1, 1'b0, 9'h0AA, {4{32'hDEADBEEF}}, 0, 3, {16{8'hA5}}, 1'b0, 1'b0, nw);
        run_miss(16'h1230, 4'd15, 1'b1, 1'b1, 9'h1FF, {4{32'h01234567}}, 2, 2, {8{16'h5A3C}}, 1'b0, 1'b0, nw);
        run_miss(16'h5A7C, 4'd9, 1'b0, 1'b1, 9'h055, {2{64'hFEEDFACECAFEF00D}}, 0, 1, {4{32'h13579BDF}}, 1'b0, 1'b0, nw);

        // Back-to-back with req_valid held: second acceptance in the first IDLE cycle.
        run_miss(16'h0450, 4'd2, 1'b1, 1'b0, 9'h003, 128'h1, 0, 2, {2{64'h0F0F0F0F0F0F0F0F}}, 1'b1, 1'b0, nw);
        run_miss(16'h8810, 4'd7, 1'b1, 1'b1, 9'h011, {4{32'hA1B2C3D4}}, 1, 2, {4{32'h99887766}}, 1'b0, 1'b0, nw);
        check("hold_accept_wait", 128'(nw), 128'(0));

        // Stray mem_resp in IDLE and in SELECT.
        addr_save = mem_addr;
        mem_resp  = 1'b1;
        @(negedge clk);
        mem_resp = 1'b0;
        @(negedge clk);
        check("stray_idle_ready", 128'(req_ready), 128'(1));
        check("stray_idle_read", 128'(mem_read | mem_write), 128'(0));
        check("stray_idle_addr", 128'(mem_addr), 128'(addr_save));
        check("stray_idle_counts", 128'({wb_count, fill_count}), 128'({16'(exp_wb), 16'(exp_fill)}));
        run_miss(16'h2368, 4'd11, 1'b1, 1'b0, 9'h100, 128'h2, 0, 2, {8{16'hC3C3}}, 1'b0, 1'b1, nw);

        // Reset pulsed while writing back.
        e = '{K_WB, 16'hFFB0, {4{32'h55AA55AA}}, 4'h0, 9'h0};
        sb.push_back(e);
        req_addr     = 16'h1230;
        victim_way   = 4'd15;
        victim_valid = 1'b1;
        victim_dirty = 1'b1;
        victim_tag   = 9'h1FF;
        victim_data  = {4{32'h55AA55AA}};
        req_valid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("wb_before_rst", 128'(mem_write), 128'(1));
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_write", 128'(mem_write), 128'(0));
        check("rst_mid_read", 128'(mem_read), 128'(0));
        check("rst_mid_counts", 128'({wb_count, fill_count}), 128'(0));
        check("rst_mid_ready", 128'(req_ready), 128'(1));
        exp_wb   = 0;
        exp_fill = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_miss(16'h1230, 4'd5, 1'b1, 1'b0, 9'h0AA, {4{32'hDEADBEEF}}, 0, 3, {16{8'hA5}}, 1'b0, 1'b0, nw);

        repeat (2) @(negedge clk);
        check("sb_empty", 128'(sb.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
